// File: rtl/counter_monitor_if.sv
// Bus between the saturating counter under observation and its monitor.
// Inputs are sampled on the rising edge of clk; outputs are registered on that edge.
interface counter_monitor_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  // No valid/ready handshake: every rising edge is one observation. The master
  // holds satEn, val_out and clr_err stable around the edge; the slave updates
  // all of its outputs from flops on that same edge.
  logic             satEn;
  logic [WIDTH-1:0] val_out;
  logic             clr_err;
  logic [WIDTH-1:0] exp_val;
  logic             err_pulse;
  logic             err_flag;
  logic [ERR_W-1:0] err_cnt;
  logic             sat_seen;
  logic [1:0]       mon_state;

  modport master (
    output satEn, val_out, clr_err,
    input  exp_val, err_pulse, err_flag, err_cnt, sat_seen, mon_state
  );

  modport slave (
    input  satEn, val_out, clr_err,
    output exp_val, err_pulse, err_flag, err_cnt, sat_seen, mon_state
  );
endinterface

// File: rtl/counter_monitor.sv
// Reference-model monitor for a non-wrapping saturating counter: tracks the
// expected value, compares the observed value every edge and keeps error status.
module counter_monitor #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  counter_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_SAT   = 2'd2,
    ST_FAIL  = 2'd3
  } mon_state_e;

  localparam logic [WIDTH-1:0] EXP_MAX = {WIDTH{1'b1}};
  localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};

  logic [WIDTH-1:0] exp_q, exp_d;
  logic             err_pulse_q, err_pulse_d;
  logic             err_flag_q, err_flag_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             sat_seen_q, sat_seen_d;
  mon_state_e       state_q, state_d;
  logic             mismatch;

  // The model never follows val_out; it only advances on satEn.
  always_comb begin
    mismatch = (mon.val_out != exp_q);

    exp_d = exp_q;
    if (mon.satEn && (exp_q != EXP_MAX)) begin
      exp_d = exp_q + {{(WIDTH-1){1'b0}}, 1'b1};
    end

    err_pulse_d = mismatch;
    err_flag_d  = mismatch | (err_flag_q & ~mon.clr_err);

    err_cnt_d = err_cnt_q;
    if (mon.clr_err) begin
      err_cnt_d = mismatch ? {{(ERR_W-1){1'b0}}, 1'b1} : '0;
    end else if (mismatch && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end

    sat_seen_d = sat_seen_q | (exp_d == EXP_MAX);
  end

  // Next state: a mismatch overrides everything, including a clear.
  always_comb begin
    state_d = state_q;
    if (mismatch) begin
      state_d = ST_FAIL;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (mon.satEn) state_d = ST_COUNT;
        end
        ST_COUNT: begin
          if (exp_d == EXP_MAX)  state_d = ST_SAT;
          else if (!mon.satEn)   state_d = ST_IDLE;
        end
        ST_SAT: begin
          if (exp_q != EXP_MAX)  state_d = ST_IDLE;
        end
        ST_FAIL: begin
          if (mon.clr_err) begin
            if (exp_q == EXP_MAX)  state_d = ST_SAT;
            else if (mon.satEn)    state_d = ST_COUNT;
            else                   state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q       <= '0;
      err_pulse_q <= 1'b0;
      err_flag_q  <= 1'b0;
      err_cnt_q   <= '0;
      sat_seen_q  <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      exp_q       <= exp_d;
      err_pulse_q <= err_pulse_d;
      err_flag_q  <= err_flag_d;
      err_cnt_q   <= err_cnt_d;
      sat_seen_q  <= sat_seen_d;
      state_q     <= state_d;
    end
  end

  assign mon.exp_val   = exp_q;
  assign mon.err_pulse = err_pulse_q;
  assign mon.err_flag  = err_flag_q;
  assign mon.err_cnt   = err_cnt_q;
  assign mon.sat_seen  = sat_seen_q;
  assign mon.mon_state = state_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Randomised bench for counter_monitor: drives an observed counter (correct,
// wrapping or corrupted) and compares every output against an integer model.
module tb_counter_monitor;
  localparam int WIDTH = 4;
  localparam int ERR_W = 8;
  localparam int MAXV  = (1 << WIDTH) - 1;
  localparam int CMAXV = (1 << ERR_W) - 1;

  localparam int MODE_OK   = 0;
  localparam int MODE_WRAP = 1;
  localparam int MODE_INV  = 2;
  localparam int MODE_RND  = 3;

  logic clk;
  logic reset;

  counter_monitor_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

  counter_monitor #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Observed counter driven into val_out, and the reference model.
  logic [WIDTH-1:0] obs;
  int m_exp, m_pulse, m_flag, m_cnt, m_sat, m_state;

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
  endtask

  task automatic check_all();
    check_eq("exp_val",   int'(bus.exp_val),   m_exp);
    check_eq("err_pulse", int'(bus.err_pulse), m_pulse);
    check_eq("err_flag",  int'(bus.err_flag),  m_flag);
    check_eq("err_cnt",   int'(bus.err_cnt),   m_cnt);
    check_eq("sat_seen",  int'(bus.sat_seen),  m_sat);
    check_eq("mon_state", int'(bus.mon_state), m_state);
  endtask

  function automatic void model_reset();
    m_exp = 0; m_pulse = 0; m_flag = 0; m_cnt = 0; m_sat = 0; m_state = 0;
  endfunction

  // One rising edge of the specified behaviour, from pre-edge model values.
  function automatic void model_edge(input bit en, input bit clr, input int v);
    bit mism;
    int n_exp;
    int n_state;
    mism  = (v != m_exp);
    n_exp = (en && m_exp < MAXV) ? m_exp + 1 : m_exp;
    if (mism) n_state = 3;
    else if (m_state == 3) begin
      if (!clr)               n_state = 3;
      else if (m_exp == MAXV) n_state = 2;
      else if (en)            n_state = 1;
      else                    n_state = 0;
    end else if (m_state == 0) n_state = en ? 1 : 0;
    else if (m_state == 1) begin
      if (n_exp == MAXV) n_state = 2;
      else               n_state = en ? 1 : 0;
    end else n_state = (m_exp == MAXV) ? 2 : 0;
    if (clr) m_cnt = mism ? 1 : 0;
    else if (mism && m_cnt < CMAXV) m_cnt = m_cnt + 1;
    m_flag  = (mism || (m_flag != 0 && !clr)) ? 1 : 0;
    m_pulse = mism ? 1 : 0;
    m_exp   = n_exp;
    if (n_exp == MAXV) m_sat = 1;
    m_state = n_state;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the following negedge.
  task automatic step(input bit en, input bit clr, input int mode);
    logic [WIDTH-1:0] drv;
    drv = obs;
    if (mode == MODE_INV) drv = ~obs;
    if (mode == MODE_RND && $urandom_range(0, 15) == 0)
      drv = obs ^ WIDTH'($urandom_range(1, MAXV));
    bus.satEn   = en;
    bus.clr_err = clr;
    bus.val_out = drv;
    @(posedge clk);
    model_edge(en, clr, int'(drv));
    if (en) begin
      if (mode == MODE_WRAP)           obs = obs + WIDTH'(1);
      else if (int'(obs) != MAXV)      obs = obs + WIDTH'(1);
    end
    #1;
    check_all();
    @(negedge clk);
  endtask

  // Called at a negedge; reset takes effect before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    obs = '0;
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset       = 1'b0;
    bus.satEn   = 1'b0;
    bus.clr_err = 1'b0;
    bus.val_out = '0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    reset       = 1'b1;
    bus.satEn   = 1'b0;
    bus.clr_err = 1'b0;
    bus.val_out = '0;
    obs         = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Full count to saturation with a correct counter.
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0, MODE_OK);
    check_eq("sat_exp",   int'(bus.exp_val),   15);
    check_eq("sat_seen1", int'(bus.sat_seen),  1);
    check_eq("sat_state", int'(bus.mon_state), 2);
    check_eq("sat_errs",  int'(bus.err_cnt),   0);

    // Async reset at negedge while saturated, then counting resumes from 0.
    bus.satEn = 1'b1;
    do_reset();
    check_eq("rst_exp0", int'(bus.exp_val),  0);
    check_eq("rst_sat0", int'(bus.sat_seen), 0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, MODE_OK);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, MODE_OK);
    check_eq("pause_exp",   int'(bus.exp_val),   7);
    check_eq("pause_state", int'(bus.mon_state), 0);
    check_eq("pause_flag",  int'(bus.err_flag),  0);

    // Wrapping counter: first bad edge samples 0 against 15.
    do_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, MODE_WRAP);
    step(1'b1, 1'b0, MODE_WRAP);
    check_eq("wrap_pulse", int'(bus.err_pulse), 1);
    check_eq("wrap_flag",  int'(bus.err_flag),  1);
    check_eq("wrap_state", int'(bus.mon_state), 3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, MODE_WRAP);
    check_eq("wrap_cnt", int'(bus.err_cnt), 4);

    // Clear coinciding with a fresh mismatch.
    step(1'b1, 1'b1, MODE_WRAP);
    check_eq("clrmis_flag",  int'(bus.err_flag),  1);
    check_eq("clrmis_cnt",   int'(bus.err_cnt),   1);
    check_eq("clrmis_state", int'(bus.mon_state), 3);

    // Repaired counter, clean clear leaves FAIL for SAT.
    obs = WIDTH'(MAXV);
    step(1'b0, 1'b1, MODE_OK);
    check_eq("clr_state", int'(bus.mon_state), 2);
    check_eq("clr_cnt",   int'(bus.err_cnt),   0);
    check_eq("clr_pulse", int'(bus.err_pulse), 0);

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, MODE_INV);
    check_eq("cnt_sat", int'(bus.err_cnt), 255);

    // Random mix of enables, sporadic corruption, clears and resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 63) == 0) do_reset();
      else step($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0, MODE_RND);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule
